// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/NOP constants, fetch state encoding,
// instruction field positions and a word-alignment helper.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // SLL $0,$0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Instruction field positions used to feed main decode
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Control-flow targets are always word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc4 with load enable and flush.
// An invalid entry always carries NOP_INSTR so decode raises no side effects.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        d_valid,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  // Flush beats load; a loaded bubble is normalised to NOP with pc4 zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (load) begin
      valid <= d_valid;
      instr <= d_valid ? d_instr : NOP_INSTR;
      pc4   <= d_valid ? d_pc4 : '0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, runs the imem request handshake,
// fills IF/ID and applies stall / branch / jump redirects.
// Optional feature macro: DELAY_SLOT_EN (MIPS branch delay slot). When it is
// undefined a taken branch flushes IF/ID and a jump squashes the next fetch.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  id_op,
  output logic [4:0]  id_select
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         redirect_pend_q, redirect_pend_d;
  logic         redirect_keep_q, redirect_keep_d;  // pending redirect keeps the response
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;

  logic         ifid_load, ifid_flush, ifid_dvalid;
  logic [31:0]  ifid_dinstr, ifid_dpc4;

  logic         fire, outstanding, jump_act, redirect;
  logic [31:0]  target, pc_plus4;

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign fire        = imem_req & imem_ready;
  assign outstanding = imem_req & ~imem_ready;
  assign pc_plus4    = pc_q + 32'd4;
  // A jump belongs to the instruction in IF/ID, so it only counts when that
  // instruction is live and actually leaves decode this cycle
  assign jump_act    = jump & ~branch_taken & ~stall & if_id_valid;
  assign redirect    = branch_taken | jump_act;
  assign target      = branch_taken ? align_word(branch_target) : align_word(jump_target);

  assign id_op       = if_id_instr[OP_MSB:OP_LSB];
  assign id_select   = if_id_instr[RT_MSB:RT_LSB];

  // Next-state for the fetch FSM, PC, pending redirect, skid and IF/ID controls
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d         = state_q;
    pc_d            = pc_q;
    redirect_pend_d = redirect_pend_q;
    redirect_keep_d = redirect_keep_q;
    redirect_pc_d   = redirect_pc_q;
    skid_instr_d    = skid_instr_q;
    skid_pc4_d      = skid_pc4_q;
    ifid_load       = ~stall;        // decode consumes IF/ID whenever not stalled
    ifid_flush      = 1'b0;
    ifid_dvalid     = 1'b0;          // nothing new arrives -> bubble
    ifid_dinstr     = imem_rdata;
    ifid_dpc4       = pc_plus4;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (fire) begin
          if (redirect_pend_q) begin
            pc_d            = redirect_pc_q;
            redirect_pend_d = 1'b0;
            redirect_keep_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
          end
          // Response is used unless an older redirect has already killed it
          if (!redirect_pend_q || redirect_keep_q) begin
            if (!stall) begin
              ifid_dvalid = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_plus4;
              state_d      = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          ifid_dvalid = 1'b1;
          ifid_dinstr = skid_instr_q;
          ifid_dpc4   = skid_pc4_q;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overlay: the address of an outstanding request must stay
    // stable, so the target is parked until the memory answers
    if (redirect) begin
      state_d         = FETCH;       // skid (if any) is abandoned
      redirect_keep_d = 1'b0;
      if (outstanding) begin
        pc_d            = pc_q;
        redirect_pend_d = 1'b1;
        redirect_pc_d   = target;
      end else begin
        pc_d            = target;
        redirect_pend_d = 1'b0;
      end
`ifdef DELAY_SLOT_EN
      if (jump_act) begin
        // The next sequential instruction is the jump's slot: let it through
        if (outstanding) redirect_keep_d = 1'b1;
      end else begin
        // Branch: IF/ID (the slot) survives, the younger fetch does not
        ifid_dvalid = 1'b0;
      end
`else
      ifid_dvalid = 1'b0;
      if (branch_taken) ifid_flush = 1'b1;
`endif
    end
  end

  // Fetch state, PC, pending redirect and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      redirect_pend_q <= 1'b0;
      redirect_keep_q <= 1'b0;
      redirect_pc_q   <= RESET_PC;
      // NOTE: the skid data is reset too; it is tiny and a known value keeps X out of IF/ID.
      skid_instr_q    <= NOP_INSTR;
      skid_pc4_q      <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_keep_q <= redirect_keep_d;
      redirect_pc_q   <= redirect_pc_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc4_q      <= skid_pc4_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .d_valid (ifid_dvalid),
    .d_instr (ifid_dinstr),
    .d_pc4   (ifid_dpc4),
    .valid   (if_id_valid),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer (default build, no delay slot).
// The model tracks the expected fetch address and the ordered list of fetched
// instructions not yet consumed by decode; a monitor compares IF/ID against it.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc4;
  logic [5:0]  id_op;
  logic [4:0]  id_select;

  int n_cmp = 0;
  int n_bad = 0;
  int n_deliv = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .id_op         (id_op),
    .id_select     (id_select)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t      q[$];        // fetched, not yet consumed; q[0] is in IF/ID when m_live
  bit          m_live = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] old_addr = RST_PC;  // address of the request a redirect is waiting on
  logic        s_req = 1'b0;
  logic [31:0] s_addr = '0;

  task automatic model_step();
    bit fire, br, jmp;
    logic [31:0] tgt, cur;
    fire = s_req && imem_ready;
    br   = branch_taken;
    jmp  = jump && !br && !stall && m_live;
    tgt  = (br ? branch_target : jump_target) & 32'hFFFF_FFFC;
    cur  = m_pend ? old_addr : exp_addr;
    if (fire) check("imem_addr", s_addr, cur);

    if (br) begin
      q.delete();
      m_live = 1'b0;
    end else if (jmp) begin
      q.delete(0);
      n_deliv++;
      q.delete();
      m_live = 1'b0;
    end else begin
      if (!stall && m_live) begin
        q.delete(0);
        n_deliv++;
      end
      if (fire && !m_pend) q.push_back('{instr: mem_word(exp_addr), pc4: exp_addr + 32'd4});
      if (!stall) m_live = (q.size() != 0);
    end

    if (fire) begin
      if (m_pend) m_pend = 1'b0;
      else exp_addr = exp_addr + 32'd4;
    end
    if (br || jmp) begin
      if (s_req && !imem_ready) begin
        old_addr = cur;
        m_pend   = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
      exp_addr = tgt;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_live   = 1'b0;
      m_pend   = 1'b0;
      exp_addr = RST_PC;
      old_addr = RST_PC;
    end else begin
      model_step();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    entry_t e;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (rst_n) begin
      check("if_id_valid", 32'(if_id_valid), 32'(m_live));
      if (m_live && q.size() > 0) begin
        e = q[0];
        check("if_id_instr", if_id_instr, e.instr);
        check("if_id_pc4", if_id_pc4, e.pc4);
        check("id_op", 32'(id_op), 32'(e.instr[31:26]));
        check("id_select", 32'(id_select), 32'(e.instr[20:16]));
      end else begin
        check("bubble_instr", if_id_instr, NOP);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit st, input bit rdy, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt);
    @(negedge clk);
    #1;
    stall         = st;
    imem_ready    = rdy;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RST_PC);
    check({tag, "_if_id_valid"}, 32'(if_id_valid), 32'd0);
    check({tag, "_if_id_instr"}, if_id_instr, NOP);
    check({tag, "_if_id_pc4"}, if_id_pc4, 32'd0);
  endtask

  task automatic release_and_check_first_req(input string tag);
    @(negedge clk);
    #1;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_first_req"}, 32'(imem_req), 32'd1);
    check({tag, "_first_addr"}, imem_addr, RST_PC);
  endtask

  // Reset asserted mid-cycle while a request is outstanding
  task automatic reset_pulse();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk);
    release_and_check_first_req("mid_rst");
  endtask

  initial begin
    logic [31:0] bt;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    release_and_check_first_req("por");

    // Back-to-back fetches
    repeat (20) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    // Memory not ready for 3 clocks
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    // Stall for 2 clocks with memory ready (skid path)
    repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    // Branch while a fetch is outstanding
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    // Branch and jump together: branch wins
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h3000_0040);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    // Jump held under stall, acted on once stall drops
    repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000_0043);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000_0043);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    // Branch near the top of the address space: pc+4 wraps
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF6, 1'b0, 32'h0);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    reset_pulse();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_pulse();
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, bt,
            $urandom_range(0, 9) == 0, $urandom);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("deliveries_seen", 32'(n_deliv > 500), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
